// File: rtl/alu4_seq_pkg.sv
// Shared types for the nibble-serial ALU sequencer: opcodes, FSM states and the
// ALU control bundle with its per-slice encoding.
package alu4_seq_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    ARITH_ISSUE,
    ARITH_WAIT,
    LOGIC_ISSUE,
    DONE
  } state_e;

  typedef struct packed {
    logic carry_in;
    logic end_bar;
    logic cmpl_x;
    logic cmpl_y;
    logic op_xor;
    logic op_and;
    logic op_arith;
  } alu_ctrl_t;

  function automatic logic op_is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Slice 0 takes the command carry (or the +1 of two's complement for SUB);
  // later slices take the carry chained from the previous slice.
  function automatic alu_ctrl_t slice_ctrl(input op_e op, input logic first,
                                           input logic cin, input logic chain);
    alu_ctrl_t c;
    c         = '0;
    c.end_bar = 1'b1;
    case (op)
      OP_ADD: begin
        c.op_arith = 1'b1;
        c.carry_in = first ? cin : chain;
      end
      OP_SUB: begin
        c.op_arith = 1'b1;
        c.cmpl_y   = 1'b1;
        c.carry_in = first ? 1'b1 : chain;
      end
      OP_AND:  c.op_and = 1'b1;
      default: c.op_xor = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu4_seq_tagpipe.sv
// LAT-deep {valid, slice index} shift register that travels alongside the ALU
// pipeline so each returning nibble knows where it belongs.
module alu4_seq_tagpipe
  import alu4_seq_pkg::*;
#(
  parameter int LAT = 7,
  parameter int IW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [IW-1:0] in_idx,
  output logic          out_vld,
  output logic [IW-1:0] out_idx
);

  logic [LAT-1:0]         vld_q, vld_d;
  logic [LAT-1:0][IW-1:0] idx_q, idx_d;

  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = in_vld;
    idx_d[0] = in_idx;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_vld = vld_q[LAT-1];
  assign out_idx = idx_q[LAT-1];

endmodule

// File: rtl/alu4_slice_sequencer.sv
// Runs wide ADD/SUB/AND/XOR on a pipelined 4-bit ALU one nibble at a time,
// chaining carry between slices for arithmetic and collecting the result word.
module alu4_slice_sequencer
  import alu4_seq_pkg::*;
#(
  parameter int LAT    = 7,
  parameter int NSLICE = 4
) (
  input  logic                gclk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic                cmd_cin,
  input  logic [4*NSLICE-1:0] cmd_x,
  input  logic [4*NSLICE-1:0] cmd_y,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*NSLICE-1:0] res_data,
  output logic                res_carry,
  output logic [3:0]          alu_x,
  output logic [3:0]          alu_y,
  output logic                alu_carry_in,
  output logic                alu_end_bar,
  output logic                alu_cmpl_x,
  output logic                alu_cmpl_y,
  output logic                alu_op_xor,
  output logic                alu_op_and,
  output logic                alu_op_arith,
  input  logic [3:0]          alu_z,
  input  logic                alu_carry_out
);

  localparam int W  = NIB * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int FW = $clog2(LAT + 1);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_e        state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic          res_carry_q, res_carry_d;
  alu_ctrl_t     ctrl_q, ctrl_d;
  logic [3:0]    alu_x_q, alu_x_d;
  logic [3:0]    alu_y_q, alu_y_d;
  logic          slice_vld_q, slice_vld_d;
  logic [IW-1:0] slice_idx_q, slice_idx_d;
  op_e           op_q, op_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;

  logic          tag_vld;
  logic [IW-1:0] tag_idx;
  logic [IW-1:0] nxt_idx;
  logic          capture;

  alu4_seq_tagpipe #(
    .LAT (LAT),
    .IW  (IW)
  ) u_tagpipe (
    .clk     (gclk),
    .rst_n   (rst_n),
    .in_vld  (slice_vld_q),
    .in_idx  (slice_idx_q),
    .out_vld (tag_vld),
    .out_idx (tag_idx)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    cmd_ready_d = cmd_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    ctrl_d      = '0;
    alu_x_d     = '0;
    alu_y_d     = '0;
    slice_vld_d = 1'b0;
    slice_idx_d = slice_idx_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    nxt_idx     = slice_idx_q + 1'b1;
    capture     = tag_vld && ((state_q == ARITH_WAIT) || (state_q == LOGIC_ISSUE));

    if (capture) begin
      res_data_d[NIB*tag_idx +: NIB] = alu_z;
      if (op_is_arith(op_q)) res_carry_d = alu_carry_out;
    end

    case (state_q)
      FLUSH: begin
        if (flush_cnt_q <= FW'(1)) begin
          flush_cnt_d = '0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = op_e'(cmd_op);
          x_d         = cmd_x;
          y_d         = cmd_y;
          res_data_d  = '0;
          res_carry_d = 1'b0;
          ctrl_d      = slice_ctrl(op_e'(cmd_op), 1'b1, cmd_cin, 1'b0);
          alu_x_d     = cmd_x[NIB-1:0];
          alu_y_d     = cmd_y[NIB-1:0];
          slice_vld_d = 1'b1;
          slice_idx_d = '0;
          state_d     = op_is_arith(op_e'(cmd_op)) ? ARITH_ISSUE : LOGIC_ISSUE;
        end
      end
      ARITH_ISSUE: state_d = ARITH_WAIT;
      ARITH_WAIT: begin
        // The next slice can only start once the previous carry has come back.
        if (capture) begin
          if (tag_idx == LAST) begin
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            ctrl_d      = slice_ctrl(op_q, 1'b0, 1'b0, alu_carry_out);
            alu_x_d     = x_q[NIB*nxt_idx +: NIB];
            alu_y_d     = y_q[NIB*nxt_idx +: NIB];
            slice_vld_d = 1'b1;
            slice_idx_d = nxt_idx;
            state_d     = ARITH_ISSUE;
          end
        end
      end
      LOGIC_ISSUE: begin
        if (slice_vld_q && (slice_idx_q != LAST)) begin
          ctrl_d      = slice_ctrl(op_q, 1'b0, 1'b0, 1'b0);
          alu_x_d     = x_q[NIB*nxt_idx +: NIB];
          alu_y_d     = y_q[NIB*nxt_idx +: NIB];
          slice_vld_d = 1'b1;
          slice_idx_d = nxt_idx;
        end
        if (capture && (tag_idx == LAST)) begin
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLUSH;
      flush_cnt_q <= FW'(LAT);
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      ctrl_q      <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      slice_vld_q <= 1'b0;
      slice_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      ctrl_q      <= ctrl_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      slice_vld_q <= slice_vld_d;
      slice_idx_q <= slice_idx_d;
    end
  end

  // Latched command operands are pure data and need no reset.
  always_ff @(posedge gclk) begin
    op_q <= op_d;
    x_q  <= x_d;
    y_q  <= y_d;
  end

  assign cmd_ready    = cmd_ready_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_carry    = res_carry_q;
  assign alu_x        = alu_x_q;
  assign alu_y        = alu_y_q;
  assign alu_carry_in = ctrl_q.carry_in;
  assign alu_end_bar  = ctrl_q.end_bar;
  assign alu_cmpl_x   = ctrl_q.cmpl_x;
  assign alu_cmpl_y   = ctrl_q.cmpl_y;
  assign alu_op_xor   = ctrl_q.op_xor;
  assign alu_op_and   = ctrl_q.op_and;
  assign alu_op_arith = ctrl_q.op_arith;

endmodule

// File: tb/tb_alu4_slice_sequencer.sv
// Bench for alu4_slice_sequencer: a bit-accurate 4-bit ALU delayed by LAT edges
// feeds the sequencer, and results are predicted with whole-word arithmetic.
module tb_alu4_slice_sequencer;

  localparam int LAT       = 7;
  localparam int NSLICE    = 4;
  localparam int W         = 4 * NSLICE;
  localparam int ARITH_LAT = NSLICE * (LAT + 1) + 1;
  localparam int LOGIC_LAT = NSLICE + LAT + 1;

  logic         gclk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic         cmd_cin = 1'b0;
  logic [W-1:0] cmd_x = '0;
  logic [W-1:0] cmd_y = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_carry;
  logic [3:0]   alu_x, alu_y, alu_z;
  logic         alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y;
  logic         alu_op_xor, alu_op_and, alu_op_arith, alu_carry_out;

  int n_cmp = 0;
  int n_bad = 0;

  int           obs_first;
  logic [W-1:0] obs_data;
  logic         obs_carry;
  int           obs_niss;
  int           obs_busy;
  int           obs_cyc [NSLICE];
  logic [14:0]  obs_sig [NSLICE];

  alu4_slice_sequencer #(.LAT(LAT), .NSLICE(NSLICE)) dut (
    .gclk(gclk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_carry(res_carry),
    .alu_x(alu_x), .alu_y(alu_y), .alu_carry_in(alu_carry_in), .alu_end_bar(alu_end_bar),
    .alu_cmpl_x(alu_cmpl_x), .alu_cmpl_y(alu_cmpl_y), .alu_op_xor(alu_op_xor),
    .alu_op_and(alu_op_and), .alu_op_arith(alu_op_arith),
    .alu_z(alu_z), .alu_carry_out(alu_carry_out)
  );

  always #5 gclk = ~gclk;

  // ALU model: garbage under reset or for a bubble, otherwise the real 4-bit function.
  function automatic logic [4:0] alu_eval(input logic rn, input logic [3:0] x, input logic [3:0] y,
                                          input logic ci, input logic cx, input logic cy,
                                          input logic ox, input logic oa, input logic oar);
    logic [3:0] xx, yy;
    xx = cx ? ~x : x;
    yy = cy ? ~y : y;
    if (!rn) return 5'($urandom);
    if (oar) return {1'b0, xx} + {1'b0, yy} + {4'b0, ci};
    if (oa)  return {1'($urandom), xx & yy};
    if (ox)  return {1'($urandom), xx ^ yy};
    return 5'($urandom);
  endfunction

  logic [4:0] mpipe [LAT];
  always @(posedge gclk) begin
    for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
    mpipe[0] <= alu_eval(rst_n, alu_x, alu_y, alu_carry_in, alu_cmpl_x, alu_cmpl_y,
                         alu_op_xor, alu_op_and, alu_op_arith);
  end
  assign alu_z         = mpipe[LAT-1][3:0];
  assign alu_carry_out = mpipe[LAT-1][4];

  // Whole-word reference: {carry, data}.
  function automatic logic [W:0] ref_result(input logic [1:0] op, input logic cin,
                                            input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      2'b00:   return {1'b0, x} + {1'b0, y} + (W+1)'(cin);
      2'b01:   return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
      2'b10:   return {1'b0, x & y};
      default: return {1'b0, x ^ y};
    endcase
  endfunction

  // Expected ALU port values for slice k: carry into bit 4k of the full-width sum.
  function automatic logic [14:0] ref_slice(input logic [1:0] op, input logic cin,
                                            input logic [W-1:0] x, input logic [W-1:0] y,
                                            input int k);
    logic [W-1:0] ye;
    logic [63:0]  m, s;
    logic         ci;
    ye = (op == 2'b01) ? ~y : y;
    ci = 1'b0;
    if (op[1] == 1'b0) begin
      m  = (64'd1 << (4 * k)) - 64'd1;
      s  = ({48'd0, x} & m) + ({48'd0, ye} & m) + ((op == 2'b01) ? 64'd1 : {63'd0, cin});
      ci = s[4*k];
    end
    return {(op[1] == 1'b0), (op == 2'b10), (op == 2'b11), (op == 2'b01), 1'b0, 1'b1, ci,
            x[4*k +: 4], y[4*k +: 4]};
  endfunction

  task automatic start_cmd(input logic [1:0] op, input logic cin, input logic [W-1:0] x,
                           input logic [W-1:0] y, input bit keep, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge gclk);
      if (cmd_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_cin   = cin;
      cmd_x     = x;
      cmd_y     = y;
      @(posedge gclk);
      #1;
      if (!keep) cmd_valid = 1'b0;
    end
  endtask

  // Called at cycle 1 (just after the acceptance edge); records issued slices and the result.
  task automatic observe(input bit consume);
    obs_first = -1;
    obs_niss  = 0;
    obs_busy  = 0;
    obs_data  = '0;
    obs_carry = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (alu_op_arith | alu_op_and | alu_op_xor) begin
        if (obs_niss < NSLICE) begin
          obs_cyc[obs_niss] = cyc;
          obs_sig[obs_niss] = {alu_op_arith, alu_op_and, alu_op_xor, alu_cmpl_y, alu_cmpl_x,
                               alu_end_bar, alu_carry_in, alu_x, alu_y};
        end
        obs_niss++;
      end
      if (res_valid === 1'b1) begin
        obs_first = cyc;
        obs_data  = res_data;
        obs_carry = res_carry;
        break;
      end
      if (cmd_ready !== 1'b0) obs_busy++;
      @(posedge gclk);
      #1;
    end
    if (consume && obs_first >= 0) begin
      @(negedge gclk);
      res_ready = 1'b1;
      @(posedge gclk);
      #1;
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (4) @(posedge gclk);
    #1;
    n_cmp++;
    if ({cmd_ready, res_valid, res_data, res_carry, alu_x, alu_y, alu_carry_in, alu_end_bar,
         alu_cmpl_x, alu_cmpl_y, alu_op_xor, alu_op_and, alu_op_arith} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: actual ready=%b valid=%b data=%h alu_x=%h required all 0",
               cmd_ready, res_valid, res_data, alu_x);
    end
    @(negedge gclk);
    rst_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge gclk);
      #1;
      n_cmp++;
      if (cmd_ready !== (i == LAT) || res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_flush edge %0d: actual ready=%b valid=%b required ready=%b valid=0",
                 i, cmd_ready, res_valid, (i == LAT));
      end
    end
  endtask

  task automatic test_op_vector(input string name, input logic [1:0] op, input logic cin,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] exp_data, input logic exp_carry);
    bit ok;
    int exp_first;
    exp_first = (op[1] == 1'b0) ? ARITH_LAT : LOGIC_LAT;
    start_cmd(op, cin, x, y, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s accept: actual cmd_ready stuck low, required 1", name);
      return;
    end
    observe(1'b1);
    n_cmp++;
    if (obs_first != exp_first) begin
      n_bad++;
      $display("FAIL %s latency: actual %0d required %0d", name, obs_first, exp_first);
    end
    n_cmp++;
    if (obs_data !== exp_data) begin
      n_bad++;
      $display("FAIL %s data: actual %h required %h", name, obs_data, exp_data);
    end
    n_cmp++;
    if (obs_carry !== exp_carry) begin
      n_bad++;
      $display("FAIL %s carry: actual %b required %b", name, obs_carry, exp_carry);
    end
    n_cmp++;
    if (obs_niss != NSLICE) begin
      n_bad++;
      $display("FAIL %s slice_count: actual %0d required %0d", name, obs_niss, NSLICE);
    end
    n_cmp++;
    if (obs_busy != 0) begin
      n_bad++;
      $display("FAIL %s busy_ready: actual %0d cycles ready required 0", name, obs_busy);
    end
    for (int k = 0; k < NSLICE && k < obs_niss; k++) begin
      n_cmp++;
      if (obs_cyc[k] != ((op[1] == 1'b0) ? 1 + k * (LAT + 1) : 1 + k)) begin
        n_bad++;
        $display("FAIL %s slice%0d_cycle: actual %0d required %0d", name, k, obs_cyc[k],
                 (op[1] == 1'b0) ? 1 + k * (LAT + 1) : 1 + k);
      end
      n_cmp++;
      if (obs_sig[k] !== ref_slice(op, cin, x, y, k)) begin
        n_bad++;
        $display("FAIL %s slice%0d_ports: actual %h required %h", name, k, obs_sig[k],
                 ref_slice(op, cin, x, y, k));
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [1:0]   op;
    logic         cin;
    logic [W-1:0] x, y;
    logic [W:0]   r;
    for (int i = 0; i < n; i++) begin
      op  = 2'($urandom);
      cin = 1'($urandom);
      x   = W'($urandom);
      y   = W'($urandom);
      r   = ref_result(op, cin, x, y);
      test_op_vector("random", op, cin, x, y, r[W-1:0], r[W]);
    end
  endtask

  task automatic test_back_to_back();
    bit           ok, held;
    logic [W-1:0] x, y, x2, y2;
    logic [W:0]   r;
    x  = W'($urandom);
    y  = W'($urandom);
    x2 = W'($urandom);
    y2 = W'($urandom);
    r  = ref_result(2'b00, 1'b1, x, y);
    start_cmd(2'b00, 1'b1, x, y, 1'b1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL b2b accept: actual cmd_ready stuck low, required 1");
      return;
    end
    observe(1'b0);
    n_cmp++;
    if (obs_first != ARITH_LAT || obs_data !== r[W-1:0]) begin
      n_bad++;
      $display("FAIL b2b first_result: actual cyc %0d data %h required cyc %0d data %h",
               obs_first, obs_data, ARITH_LAT, r[W-1:0]);
    end
    @(negedge gclk);
    cmd_op = 2'b11;
    cmd_x  = x2;
    cmd_y  = y2;
    held   = 1'b1;
    repeat (10) begin
      @(posedge gclk);
      #1;
      if (res_valid !== 1'b1 || res_data !== r[W-1:0] || res_carry !== r[W] || cmd_ready !== 1'b0)
        held = 1'b0;
    end
    n_cmp++;
    if (!held) begin
      n_bad++;
      $display("FAIL b2b hold: actual valid=%b data=%h carry=%b ready=%b required 1/%h/%b/0",
               res_valid, res_data, res_carry, cmd_ready, r[W-1:0], r[W]);
    end
    @(negedge gclk);
    res_ready = 1'b1;
    @(posedge gclk);
    #1;
    res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b handshake: actual valid=%b ready=%b required valid=0 ready=1",
               res_valid, cmd_ready);
    end
    @(posedge gclk);
    #1;
    cmd_valid = 1'b0;
    observe(1'b1);
    n_cmp++;
    if (obs_niss < 1 || obs_cyc[0] != 1) begin
      n_bad++;
      $display("FAIL b2b second_accept: actual first slice cycle %0d required 1",
               (obs_niss < 1) ? -1 : obs_cyc[0]);
    end
    n_cmp++;
    if (obs_first != LOGIC_LAT || obs_data !== (x2 ^ y2) || obs_carry !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b second_result: actual cyc %0d data %h carry %b required %0d %h 0",
               obs_first, obs_data, obs_carry, LOGIC_LAT, x2 ^ y2);
    end
  endtask

  task automatic test_reset_mid();
    bit           ok;
    logic [W-1:0] x2, y2;
    x2 = W'($urandom);
    y2 = W'($urandom);
    start_cmd(2'b00, 1'b0, W'($urandom), W'($urandom), 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL reset_mid accept: actual cmd_ready stuck low, required 1");
      return;
    end
    repeat (14) @(posedge gclk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, res_valid, res_data, res_carry, alu_x, alu_y, alu_carry_in, alu_end_bar,
         alu_cmpl_x, alu_cmpl_y, alu_op_xor, alu_op_and, alu_op_arith} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid outputs: actual ready=%b valid=%b data=%h ctrl=%b required all 0",
               cmd_ready, res_valid, res_data, alu_op_arith);
    end
    repeat (3) @(negedge gclk);
    rst_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge gclk);
      #1;
      n_cmp++;
      if (cmd_ready !== (i == LAT) || res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid flush edge %0d: actual ready=%b valid=%b required ready=%b valid=0",
                 i, cmd_ready, res_valid, (i == LAT));
      end
    end
    test_op_vector("xor_after_reset", 2'b11, 1'b0, x2, y2, x2 ^ y2, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_op_vector("add_1234_0fff", 2'b00, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0);
    test_op_vector("add_ffff_0001", 2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    test_op_vector("sub_0005_0007", 2'b01, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
    test_op_vector("and_f0f0_3c3c", 2'b10, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);
    test_op_vector("xor_ffff_1234", 2'b11, 1'b1, 16'hFFFF, 16'h1234, 16'hEDCB, 1'b0);
    test_random(12);
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
